// File: rtl/hazard_scoreboard.sv
// Register-pending-write scoreboard for an in-order read stage.
// Tracks outstanding writes to R0..R6 and holds issue on RAW hazards, full counters or flush.
module hazard_scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd1_en,
    input  logic [2:0] rd1_add,
    input  logic       rd2_en,
    input  logic [2:0] rd2_add,
    input  logic       issue_valid,
    input  logic       issue_wen,
    input  logic [2:0] issue_dest,
    input  logic       wb_valid,
    input  logic [2:0] wb_add,
    input  logic       flush,
    output logic       stall,
    output logic       issue_fire,
    output logic [7:0] busy,
    output logic [1:0] state,
    output logic [7:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t     st_q, st_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic [1:0] cnt    [7];
    logic [1:0] cnt_rd [8];
    logic       hazard, dest_full, inc, dec;

    // R7 is the PC and is never tracked, so its view is tied to zero.
    always_comb begin
        for (int unsigned i = 0; i < 7; i++) begin
            cnt_rd[i] = cnt[i];
        end
        cnt_rd[7] = '0;
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            busy[i] = (cnt_rd[i] != '0);
        end
    end

    assign hazard     = (rd1_en && (cnt_rd[rd1_add] != '0)) ||
                        (rd2_en && (cnt_rd[rd2_add] != '0));
    assign dest_full  = issue_wen && (issue_dest != 3'd7) && (cnt_rd[issue_dest] == 2'd3);
    assign stall      = issue_valid && ((st_q == FLUSH) || flush || hazard || dest_full);
    assign issue_fire = issue_valid && !stall;
    assign inc        = issue_fire && issue_wen && (issue_dest != 3'd7);
    assign dec        = wb_valid && (wb_add != 3'd7) && (cnt_rd[wb_add] != '0);
    assign state      = st_q;

    always_comb begin
        st_d   = st_q;
        fcnt_d = fcnt_q;
        if (flush) begin
            st_d   = FLUSH;
            fcnt_d = 2'd2;
        end else if (st_q == FLUSH) begin
            fcnt_d = fcnt_q - 2'd1;
            if (fcnt_q <= 2'd1) begin
                st_d   = RUN;
                fcnt_d = '0;
            end
        end else begin
            st_d = (issue_valid && (hazard || dest_full)) ? STALL : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q         <= RUN;
            fcnt_q       <= '0;
            stall_cycles <= '0;
            for (int unsigned i = 0; i < 7; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            st_q   <= st_d;
            fcnt_q <= fcnt_d;
            if (stall && (stall_cycles != 8'hFF)) begin
                stall_cycles <= stall_cycles + 8'd1;
            end
            // Simultaneous issue and retire on one register cancel out.
            for (int unsigned i = 0; i < 7; i++) begin
                if (inc && (issue_dest == 3'(i)) && !(dec && (wb_add == 3'(i)))) begin
                    cnt[i] <= cnt[i] + 2'd1;
                end else if (dec && (wb_add == 3'(i)) && !(inc && (issue_dest == 3'(i)))) begin
                    cnt[i] <= cnt[i] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic against a per-register pending-write count model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset, rd1_en, rd2_en, issue_valid, issue_wen, wb_valid, flush;
    logic [2:0] rd1_add, rd2_add, issue_dest, wb_add;
    logic       stall, issue_fire;
    logic [7:0] busy, stall_cycles;
    logic [1:0] state;
    logic [19:0] obs;

    int errors = 0;
    int checks = 0;

    // Reference model: pending writes per register, mode (0 run, 1 stall, 2 flush),
    // remaining flush cycles and stalled-cycle total.
    int mcnt [8];
    int mstate, mflush_left, msc;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .rd1_en(rd1_en), .rd1_add(rd1_add),
        .rd2_en(rd2_en), .rd2_add(rd2_add),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_dest(issue_dest),
        .wb_valid(wb_valid), .wb_add(wb_add), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .busy(busy),
        .state(state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;
    assign obs = {stall, issue_fire, busy, state, stall_cycles};

    function automatic logic [19:0] expv();
        bit haz, full, st, fi;
        logic [7:0] b;
        logic [1:0] s;
        logic [7:0] c;
        haz  = (rd1_en && mcnt[rd1_add] != 0) || (rd2_en && mcnt[rd2_add] != 0);
        full = issue_wen && issue_dest != 3'd7 && mcnt[issue_dest] == 3;
        st   = issue_valid && (mstate == 2 || flush || haz || full);
        fi   = issue_valid && !st;
        for (int i = 0; i < 8; i++) b[i] = (mcnt[i] != 0);
        s = 2'(mstate);
        c = 8'(msc);
        return {st, fi, b, s, c};
    endfunction

    task automatic idle();
        reset = 1'b1; rd1_en = 0; rd2_en = 0; issue_valid = 0; issue_wen = 0;
        wb_valid = 0; flush = 0; rd1_add = 0; rd2_add = 0; issue_dest = 0; wb_add = 0;
    endtask

    task automatic tick();
        logic [19:0] e;
        bit haz, full, inc, dec;
        e    = expv();
        haz  = (rd1_en && mcnt[rd1_add] != 0) || (rd2_en && mcnt[rd2_add] != 0);
        full = issue_wen && issue_dest != 3'd7 && mcnt[issue_dest] == 3;
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 8; i++) mcnt[i] = 0;
            mstate = 0; mflush_left = 0; msc = 0;
        end else begin
            inc = e[18] && issue_wen && issue_dest != 3'd7;
            dec = wb_valid && wb_add != 3'd7 && mcnt[wb_add] != 0;
            if (!(inc && dec && issue_dest == wb_add)) begin
                if (inc) mcnt[issue_dest] = mcnt[issue_dest] + 1;
                if (dec) mcnt[wb_add] = mcnt[wb_add] - 1;
            end
            if (flush) begin
                mstate = 2; mflush_left = 2;
            end else if (mstate == 2) begin
                mflush_left = mflush_left - 1;
                if (mflush_left <= 0) begin mstate = 0; mflush_left = 0; end
            end else begin
                mstate = (issue_valid && (haz || full)) ? 1 : 0;
            end
            if (e[19] && msc < 255) msc = msc + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); reset = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        checks++;
        if (obs !== 20'h0) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", obs, 20'h0);
        end
    endtask

    task automatic test_raw_hazard();
        idle(); issue_valid = 1; issue_wen = 1; issue_dest = 3;
        #2; checks++;
        if (issue_fire !== 1'b1) begin errors++; $display("FAIL raw_issue got=%b exp=1", issue_fire); end
        tick();
        idle(); issue_valid = 1; rd1_en = 1; rd1_add = 3;
        #2; checks++;
        if ({busy, stall} !== {8'h08, 1'b1}) begin
            errors++; $display("FAIL raw_stall got=%h exp=%h", {busy, stall}, {8'h08, 1'b1});
        end
        tick();
        wb_valid = 1; wb_add = 3;
        #2; checks++;
        if ({state, stall} !== {2'b01, 1'b1}) begin
            errors++; $display("FAIL raw_state_nobypass got=%h exp=%h", {state, stall}, {2'b01, 1'b1});
        end
        tick();
        wb_valid = 0;
        #2; checks++;
        if ({busy, issue_fire} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL raw_release got=%h exp=%h", {busy, issue_fire}, {8'h00, 1'b1});
        end
        tick();
    endtask

    task automatic test_dest_full();
        idle(); issue_valid = 1; issue_wen = 1; issue_dest = 2;
        for (int k = 0; k < 3; k++) begin
            #2; checks++;
            if (issue_fire !== 1'b1) begin errors++; $display("FAIL full_fill%0d got=%b exp=1", k, issue_fire); end
            tick();
        end
        #2; checks++;
        if ({busy, stall, issue_fire} !== {8'h04, 2'b10}) begin
            errors++; $display("FAIL full_stall got=%h exp=%h", {busy, stall, issue_fire}, {8'h04, 2'b10});
        end
        wb_valid = 1; wb_add = 2;
        tick();
        wb_valid = 0;
        #2; checks++;
        if (issue_fire !== 1'b1) begin errors++; $display("FAIL full_refire got=%b exp=1", issue_fire); end
        tick();
        idle(); wb_valid = 1; wb_add = 2;
        repeat (3) tick();
        idle(); #2; checks++;
        if (obs !== expv() || busy !== 8'h00) begin
            errors++; $display("FAIL full_drain got=%h exp=%h", obs, expv());
        end
    endtask

    task automatic test_same_cycle();
        idle(); issue_valid = 1; issue_wen = 1; issue_dest = 5;
        tick();
        wb_valid = 1; wb_add = 5;
        #2; checks++;
        if (issue_fire !== 1'b1) begin errors++; $display("FAIL same_fire got=%b exp=1", issue_fire); end
        tick();
        idle(); #2; checks++;
        if (busy !== 8'h20 || obs !== expv()) begin
            errors++; $display("FAIL same_cancel got=%h exp=%h", busy, 8'h20);
        end
        wb_valid = 1; wb_add = 5;
        tick();
        idle(); #2; checks++;
        if (busy !== 8'h00) begin errors++; $display("FAIL same_drain got=%h exp=00", busy); end
    endtask

    task automatic test_flush();
        int sc0;
        sc0 = msc;
        idle(); issue_valid = 1; flush = 1;
        #2; checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL flush_cycle got=%b exp=1", stall); end
        tick();
        flush = 0;
        for (int k = 0; k < 2; k++) begin
            #2; checks++;
            if ({state, stall} !== {2'b10, 1'b1}) begin
                errors++; $display("FAIL flush_hold%0d got=%h exp=%h", k, {state, stall}, {2'b10, 1'b1});
            end
            tick();
        end
        #2; checks++;
        if ({state, issue_fire, stall_cycles} !== {2'b00, 1'b1, 8'(sc0 + 3)}) begin
            errors++; $display("FAIL flush_exit got=%h exp=%h",
                {state, issue_fire, stall_cycles}, {2'b00, 1'b1, 8'(sc0 + 3)});
        end
        tick();
    endtask

    task automatic test_r7();
        idle(); issue_valid = 1; issue_wen = 1; issue_dest = 7;
        #2; checks++;
        if ({issue_fire, busy} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL r7_issue got=%h exp=%h", {issue_fire, busy}, {1'b1, 8'h00});
        end
        tick();
        idle(); issue_valid = 1; rd1_en = 1; rd1_add = 7; rd2_en = 1; rd2_add = 4;
        wb_valid = 1; wb_add = 7;
        #2; checks++;
        if ({stall, busy} !== 9'h000) begin errors++; $display("FAIL r7_nostall got=%h exp=000", {stall, busy}); end
        tick();
        wb_add = 4;
        tick();
        idle(); #2; checks++;
        if (busy !== 8'h00) begin errors++; $display("FAIL idle_wb got=%h exp=00", busy); end
    endtask

    task automatic test_reset_mid_flush();
        idle(); issue_valid = 1; issue_wen = 1; issue_dest = 1;
        repeat (2) tick();
        idle(); flush = 1;
        tick();
        idle(); #2; checks++;
        if ({state, busy} !== {2'b10, 8'h02}) begin
            errors++; $display("FAIL prerst got=%h exp=%h", {state, busy}, {2'b10, 8'h02});
        end
        reset = 0; flush = 1; issue_valid = 1; issue_wen = 1; issue_dest = 1; wb_valid = 1; wb_add = 1;
        tick();
        idle(); #2; checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL rst_midflush got=%h exp=%h", obs, 20'h0); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) != 0);
            rd1_en      = 1'($urandom); rd1_add = 3'($urandom);
            rd2_en      = 1'($urandom); rd2_add = 3'($urandom);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_wen   = ($urandom_range(0, 3) != 0);
            issue_dest  = 3'($urandom);
            wb_valid    = 1'($urandom); wb_add = 3'($urandom);
            flush       = ($urandom_range(0, 15) == 0);
            #2; checks++;
            if (obs !== expv() || (stall && issue_fire)) begin
                errors++; $display("FAIL random_cycle%0d got=%h exp=%h", n, obs, expv());
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
        mstate = 0; mflush_left = 0; msc = 0;
        idle();
        #1;
        test_reset();
        test_raw_hazard();
        test_dest_full();
        test_same_cycle();
        test_flush();
        test_r7();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
